// File: rtl/latch_cap_pkg.sv
// Shared types for the latch-capture block: FSM state encoding and synchroniser limits.
package latch_cap_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_HOLD   = 2'd3
    } cap_state_e;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/latch_capture_sync.sv
// Captures a transparent latch's closed-window value into the clk domain once the
// synchronised enable has closed and settled, then offers it on a valid/ready port.
module latch_capture_sync
    import latch_cap_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             latch_en,
    input  logic [WIDTH-1:0] latch_q,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic [CNT_W-1:0] capture_count
);

    localparam int unsigned SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
    localparam int unsigned SET_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    cap_state_e       state, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             en_s, en_prev;
    logic             en_rise, en_fall;
    logic             capture, accept, ovr_set;

    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_d;
    logic             overrun_d;
    logic [CNT_W-1:0] capture_count_d;

    // latch_q is deliberately not synchronised; it is only sampled after close + settle.
    bit_sync #(
        .STAGES (SYNC_N)
    ) u_en_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (latch_en),
        .q     (en_s)
    );

    assign en_rise = en_s & ~en_prev;
    assign en_fall = ~en_s & en_prev;

    // Next-state, capture and handshake decode.
    always_comb begin
        state_d  = state;
        settle_d = settle_q;
        capture  = 1'b0;
        accept   = 1'b0;
        ovr_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_rise) begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (en_fall) begin
                    state_d  = ST_SETTLE;
                    settle_d = SET_W'(STABLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (en_rise) begin
                    state_d = ST_OPEN;
                end else if (settle_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            ST_HOLD: begin
                if (out_valid && out_ready) begin
                    accept  = 1'b1;
                    state_d = en_s ? ST_OPEN : ST_IDLE;
                end else if (en_rise) begin
                    ovr_set = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register next values; overrun set wins over clear.
    always_comb begin
        out_data_d      = out_data;
        out_valid_d     = out_valid;
        overrun_d       = overrun;
        capture_count_d = capture_count;
        if (capture) begin
            out_data_d      = latch_q;
            out_valid_d     = 1'b1;
            capture_count_d = capture_count + CNT_W'(1);
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            settle_q      <= '0;
            en_prev       <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            overrun       <= 1'b0;
            capture_count <= '0;
        end else begin
            state         <= state_d;
            settle_q      <= settle_d;
            en_prev       <= en_s;
            out_data      <= out_data_d;
            out_valid     <= out_valid_d;
            overrun       <= overrun_d;
            capture_count <= capture_count_d;
        end
    end

endmodule
